// File: rtl/mem_if_pkg.sv
// Shared types for the data-port responder: queued request entry, FSM states, lane count.
// The request queue stores word addresses WORD_ADDR_W bits wide, so ADDR_W on the top must match it.
package mem_if_pkg;

    localparam int WORD_ADDR_W = 12;
    localparam int BYTE_LANES  = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } fsm_state_t;

    typedef struct packed {
        logic                   wr;
        logic [BYTE_LANES-1:0]  wen;
        logic [WORD_ADDR_W-1:0] word;
        logic [31:0]            wdata;
        logic                   oor;
    } req_entry_t;

endpackage

// File: rtl/req_fifo.sv
// DEPTH-entry circular queue of accepted requests; head is the oldest outstanding entry.
module req_fifo
    import mem_if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  req_entry_t       push_entry,
    input  logic             pop,
    output req_entry_t       head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    req_entry_t       slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guards keep count inside 0..DEPTH even if a caller misbehaves.
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder: in-order req/addr_ok -> data_ok with programmable wait states,
// byte-enable RAM, out-of-range detection and a sticky error flag.
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = WORD_ADDR_W,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] WCNT_RELOAD = LAT_W'(LATENCY - 1);

    fsm_state_t       state_q, state_d;
    logic [LAT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             resp;
    logic             oor;
    req_entry_t       new_entry;
    req_entry_t       head;
    logic [31:0]      ram [2**ADDR_W];

    assign data_addr_ok = (count < CNT_W'(DEPTH));
    assign push         = data_req && data_addr_ok;
    assign oor          = |data_addr[31:ADDR_W+2];

    assign new_entry = '{wr: data_wr, wen: data_wen, word: data_addr[ADDR_W+1:2],
                         wdata: data_wdata, oor: oor};

    req_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (new_entry),
        .pop        (resp),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        resp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = WAIT;
                    wcnt_d  = WCNT_RELOAD;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    resp = 1'b1;
                    // Something left behind the popped head (or arriving now) starts a fresh wait.
                    if ((count > CNT_W'(1)) || push) begin
                        wcnt_d = WCNT_RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (push && oor) err_o <= 1'b1;
        end
    end

    assign data_data_ok = resp;
    assign data_rdata   = (resp && !head.wr && !head.oor) ? ram[head.word] : 32'h0;

    always_ff @(posedge clk) begin
        if (resp && head.wr && !head.oor) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (head.wen[i]) ram[head.word][8*i +: 8] <= head.wdata[8*i +: 8];
            end
        end
    end

endmodule
